// File: rtl/cbus_arbiter_pkg.sv
// Shared cache-bus types, arbitration policy constants and FSM state encoding.
package common;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [3:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  // Grant index width; a single requester still gets a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cbus_arbiter_pick.sv
// Combinational winner selection: fixed priority (highest index) or round-robin.
module cbus_arb_pick
  import common::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned POLICY  = ARB_FIXED
) (
  input  logic [NUM_REQ-1:0]             valid,
  input  logic [idx_width(NUM_REQ)-1:0]  rr_ptr,
  output logic [idx_width(NUM_REQ)-1:0]  winner,
  output logic                           any_valid
);

  localparam int unsigned IW = idx_width(NUM_REQ);

  logic [IW-1:0] cand;

  // Scan candidates; later hits overwrite earlier ones, so the scan order
  // encodes the priority (ascending index for fixed, descending distance for RR).
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    cand      = '0;
    if (POLICY == ARB_FIXED) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (valid[IW'(i)]) begin
          winner    = IW'(i);
          any_valid = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = NUM_REQ; k > 0; k--) begin
        cand = IW'((32'(rr_ptr) + k) % NUM_REQ);
        if (valid[cand]) begin
          winner    = cand;
          any_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Cache-bus arbiter: grants one requester per transaction and holds the grant
// until the memory side signals the last beat.
module cbus_arbiter
  import common::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned POLICY  = ARB_FIXED
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  cbus_req_t                      ireqs  [NUM_REQ],
  output cbus_resp_t                     iresps [NUM_REQ],
  output cbus_req_t                      oreq,
  input  cbus_resp_t                     oresp,
  output logic                           busy,
  output logic [idx_width(NUM_REQ)-1:0]  grant_idx
);

  localparam int unsigned IW = idx_width(NUM_REQ);

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     sel_q, sel_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] req_valid;
  logic [IW-1:0]     winner;
  logic              any_valid;

  // Gather request valids for the selector.
  always_comb begin
    req_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = ireqs[i].valid;
    end
  end

  cbus_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .POLICY  (POLICY)
  ) u_pick (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      rr_ptr_q <= IW'(NUM_REQ - 1);
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state logic and bus muxing; the bus is only connected while granted.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    oreq     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      iresps[i] = '0;
    end
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d  = BUSY;
          sel_d    = winner;
          rr_ptr_d = winner;
        end
      end
      BUSY: begin
        oreq          = ireqs[sel_q];
        iresps[sel_q] = oresp;
        if (oresp.ready && oresp.last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == BUSY);
  assign grant_idx = sel_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: fixed-priority instance driven from a
// vector table plus hand sequences; a round-robin instance for alternation.
module tb_cbus_arbiter;
  import common::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  cbus_req_t  ireqs_f  [2];
  cbus_resp_t iresps_f [2];
  cbus_req_t  oreq_f;
  cbus_resp_t oresp_f;
  logic       busy_f;
  logic [0:0] gidx_f;

  cbus_req_t  ireqs_r  [2];
  cbus_resp_t iresps_r [2];
  cbus_req_t  oreq_r;
  cbus_resp_t oresp_r;
  logic       busy_r;
  logic [0:0] gidx_r;

  cbus_arbiter #(.NUM_REQ(2), .POLICY(ARB_FIXED)) u_fix (
    .clk       (clk),
    .resetn    (resetn),
    .ireqs     (ireqs_f),
    .iresps    (iresps_f),
    .oreq      (oreq_f),
    .oresp     (oresp_f),
    .busy      (busy_f),
    .grant_idx (gidx_f)
  );

  cbus_arbiter #(.NUM_REQ(2), .POLICY(ARB_RR)) u_rr (
    .clk       (clk),
    .resetn    (resetn),
    .ireqs     (ireqs_r),
    .iresps    (iresps_r),
    .oreq      (oreq_r),
    .oresp     (oresp_r),
    .busy      (busy_r),
    .grant_idx (gidx_r)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // in  = {v0, v1, ready, last}; exp = {busy, grant_idx, oreq.valid, r0, r1}
  typedef struct {
    logic [3:0]  in;
    logic [4:0]  exp;
    logic [15:0] addr;
  } vec_t;

  vec_t tbl [19];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Fixed priority, then burst hold, then valid dropped while granted.
    tbl[0]  = '{4'b1100, 5'b00000, 16'h0000};
    tbl[1]  = '{4'b1111, 5'b11101, 16'h2000};
    tbl[2]  = '{4'b1000, 5'b01000, 16'h0000};
    tbl[3]  = '{4'b1011, 5'b10110, 16'h1000};
    tbl[4]  = '{4'b1000, 5'b00000, 16'h0000};
    tbl[5]  = '{4'b1010, 5'b10110, 16'h1000};
    tbl[6]  = '{4'b1100, 5'b10100, 16'h1000};
    tbl[7]  = '{4'b1110, 5'b10110, 16'h1000};
    tbl[8]  = '{4'b1100, 5'b10100, 16'h1000};
    tbl[9]  = '{4'b1110, 5'b10110, 16'h1000};
    tbl[10] = '{4'b1100, 5'b10100, 16'h1000};
    tbl[11] = '{4'b1111, 5'b10110, 16'h1000};
    tbl[12] = '{4'b0100, 5'b00000, 16'h0000};
    tbl[13] = '{4'b0111, 5'b11101, 16'h2000};
    tbl[14] = '{4'b0000, 5'b01000, 16'h0000};
    tbl[15] = '{4'b1000, 5'b01000, 16'h0000};
    tbl[16] = '{4'b0000, 5'b10000, 16'h1000};
    tbl[17] = '{4'b0011, 5'b10010, 16'h1000};
    tbl[18] = '{4'b0000, 5'b00000, 16'h0000};

    resetn      = 1'b0;
    ireqs_f[0]  = '0;
    ireqs_f[1]  = '0;
    ireqs_r[0]  = '0;
    ireqs_r[1]  = '0;
    oresp_f     = '0;
    oresp_r     = '0;
    ireqs_f[0].addr = 64'h1000;
    ireqs_f[1].addr = 64'h2000;
    ireqs_r[0].addr = 64'h3000;
    ireqs_r[1].addr = 64'h4000;

    // Reset held with a pending request: everything stays quiet.
    ireqs_f[0].valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_oreq_valid", oreq_f.valid, 0);
    chk("rst_busy", busy_f, 0);
    chk("rst_gidx", gidx_f, 0);
    chk("rst_iresp0", iresps_f[0], 0);
    chk("rst_iresp1", iresps_f[1], 0);
    resetn = 1'b1;
    #1;
    chk("rel_oreq_valid_lat", oreq_f.valid, 0);
    @(negedge clk);
    #1;
    chk("rel_oreq_valid", oreq_f.valid, 1);
    chk("rel_oreq_addr", oreq_f.addr, 64'h1000);
    chk("rel_busy", busy_f, 1);
    oresp_f.ready = 1'b1;
    oresp_f.last  = 1'b1;
    oresp_f.data  = 64'h55;
    #1;
    chk("rel_iresp0_ready", iresps_f[0].ready, 1);
    chk("rel_iresp0_data", iresps_f[0].data, 64'h55);
    @(negedge clk);
    ireqs_f[0].valid = 1'b0;
    oresp_f = '0;
    #1;
    chk("rel_done_busy", busy_f, 0);

    // Table-driven cycles.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      ireqs_f[0].valid = tbl[i].in[3];
      ireqs_f[1].valid = tbl[i].in[2];
      oresp_f.ready    = tbl[i].in[1];
      oresp_f.last     = tbl[i].in[0];
      oresp_f.data     = 64'h55;
      #1;
      chk($sformatf("v%0d_busy", i), busy_f, tbl[i].exp[4]);
      chk($sformatf("v%0d_gidx", i), gidx_f, tbl[i].exp[3]);
      chk($sformatf("v%0d_ovalid", i), oreq_f.valid, tbl[i].exp[2]);
      chk($sformatf("v%0d_oaddr", i), oreq_f.addr, {48'h0, tbl[i].addr});
      chk($sformatf("v%0d_r0", i), iresps_f[0].ready, tbl[i].exp[1]);
      chk($sformatf("v%0d_r1", i), iresps_f[1].ready, tbl[i].exp[0]);
    end

    // Write passthrough: two beats on port 1, data changes once accepted.
    @(negedge clk);
    oresp_f = '0;
    ireqs_f[1].valid    = 1'b1;
    ireqs_f[1].is_write = 1'b1;
    ireqs_f[1].len      = 4'd1;
    ireqs_f[1].strobe   = 8'hFF;
    ireqs_f[1].data     = 64'hAA;
    #1;
    chk("wr_idle_busy", busy_f, 0);
    @(negedge clk);
    #1;
    chk("wr_busy", busy_f, 1);
    chk("wr_gidx", gidx_f, 1);
    chk("wr_beat0_data", oreq_f.data, 64'hAA);
    chk("wr_is_write", oreq_f.is_write, 1);
    chk("wr_len", oreq_f.len, 1);
    oresp_f.ready = 1'b1;
    #1;
    chk("wr_beat0_ready", iresps_f[1].ready, 1);
    chk("wr_beat0_last", iresps_f[1].last, 0);
    chk("wr_loser_quiet", iresps_f[0], 0);
    @(negedge clk);
    ireqs_f[1].data = 64'hBB;
    oresp_f.ready = 1'b1;
    oresp_f.last  = 1'b1;
    #1;
    chk("wr_beat1_data", oreq_f.data, 64'hBB);
    chk("wr_beat1_last", iresps_f[1].last, 1);
    chk("wr_beat1_busy", busy_f, 1);
    @(negedge clk);
    ireqs_f[1].valid    = 1'b0;
    ireqs_f[1].is_write = 1'b0;
    oresp_f = '0;
    #1;
    chk("wr_done_busy", busy_f, 0);

    // Asynchronous reset during the second beat of a burst.
    @(negedge clk);
    ireqs_f[0].valid = 1'b1;
    ireqs_f[0].len   = 4'd3;
    @(negedge clk);
    oresp_f.ready = 1'b1;
    @(negedge clk);
    oresp_f.ready = 1'b0;
    @(negedge clk);
    oresp_f.ready = 1'b1;
    #1;
    chk("mrst_pre_valid", oreq_f.valid, 1);
    #1;
    resetn = 1'b0;
    #1;
    chk("mrst_oreq_valid", oreq_f.valid, 0);
    chk("mrst_busy", busy_f, 0);
    chk("mrst_iresp0", iresps_f[0].ready, 0);
    oresp_f = '0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("mrst_rel_busy", busy_f, 0);
    @(negedge clk);
    #1;
    chk("mrst_regrant_busy", busy_f, 1);
    chk("mrst_regrant_gidx", gidx_f, 0);
    chk("mrst_regrant_valid", oreq_f.valid, 1);
    oresp_f.ready = 1'b1;
    oresp_f.last  = 1'b1;
    @(negedge clk);
    ireqs_f[0].valid = 1'b0;
    oresp_f = '0;
    #1;
    chk("mrst_done_busy", busy_f, 0);

    // Round-robin: both ports always valid, single-beat transactions.
    @(negedge clk);
    ireqs_r[0].valid = 1'b1;
    ireqs_r[1].valid = 1'b1;
    oresp_r.ready = 1'b1;
    oresp_r.last  = 1'b1;
    oresp_r.data  = 64'h77;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      #1;
      if (k % 2 == 1) begin
        int g;
        g = ((k - 1) / 2) % 2;
        chk($sformatf("rr%0d_busy", k), busy_r, 1);
        chk($sformatf("rr%0d_gidx", k), gidx_r, g);
        chk($sformatf("rr%0d_oaddr", k), oreq_r.addr, (g == 1) ? 64'h4000 : 64'h3000);
        chk($sformatf("rr%0d_r0", k), iresps_r[0].ready, (g == 0) ? 1 : 0);
        chk($sformatf("rr%0d_r1", k), iresps_r[1].ready, (g == 1) ? 1 : 0);
      end else begin
        chk($sformatf("rr%0d_busy", k), busy_r, 0);
        chk($sformatf("rr%0d_ovalid", k), oreq_r.valid, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
